// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, 4-bit key encode.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_encoder #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000,
    parameter int REPEAT_DLY   = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);

    generate
        if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DLY < 1) begin : g_bad_param
            $error("keypad_scan_encoder: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    rs_meta, rs;
    logic [1:0]    col, col_n;
    logic [DW-1:0] div, div_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    pat, pat_n;
    logic [3:0]    code_n;
    logic          valid_n, held_n;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY - 1);
    logic [RW-1:0] rep, rep_n;
`endif

    function automatic logic one_low(input logic [3:0] r);
        case (r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] encode(input logic [1:0] c, input logic [3:0] p);
        logic [1:0] r;
        case (p)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({c, r})
            4'b00_00: encode = 4'h1;
            4'b00_01: encode = 4'h4;
            4'b00_10: encode = 4'h7;
            4'b00_11: encode = 4'hF;
            4'b01_00: encode = 4'h2;
            4'b01_01: encode = 4'h5;
            4'b01_10: encode = 4'h8;
            4'b01_11: encode = 4'h0;
            4'b10_00: encode = 4'h3;
            4'b10_01: encode = 4'h6;
            4'b10_10: encode = 4'h9;
            4'b10_11: encode = 4'hE;
            4'b11_00: encode = 4'hA;
            4'b11_01: encode = 4'hB;
            4'b11_10: encode = 4'hC;
            default:  encode = 4'hD;
        endcase
    endfunction

    // Column register only moves on slot boundaries, so the decode is glitch-free.
    assign col_out = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= row_in;
            rs      <= rs_meta;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        div_n   = div;
        cnt_n   = cnt;
        pat_n   = pat;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = '0;
`endif
        case (state)
            SCAN: begin
                if (div == DIV_LAST) begin
                    div_n = '0;
                    if (one_low(rs)) begin
                        pat_n   = rs;
                        cnt_n   = '0;
                        state_n = DEB_PRESS;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (rs != pat) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    div_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = HELD;
                    code_n  = encode(col, pat);
                    valid_n = 1'b1;
                    held_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
                end
            end
            HELD: begin
                // Only the latched column is driven, so other columns stay invisible here.
                if (rs == 4'hF) begin
                    state_n = DEB_RELEASE;
                    cnt_n   = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep == REP_LAST) begin
                    valid_n = 1'b1;
                end else begin
                    rep_n = rep + 1'b1;
                end
`endif
            end
            default: begin
                if (rs != 4'hF) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = SCAN;
                    held_n  = 1'b0;
                    col_n   = 2'd0;
                    div_n   = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col       <= 2'd0;
            div       <= '0;
            cnt       <= '0;
            pat       <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
`endif
        end else begin
            state     <= state_n;
            col       <= col_n;
            div       <= div_n;
            cnt       <= cnt_n;
            pat       <= pat_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
`ifdef KEYPAD_REPEAT_EN
            rep       <= rep_n;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad matrix model drives the rows from col_out,
// a monitor logs key_valid pulses, and each task checks against the key layout.
module tb_keypad_scan_encoder;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 10;
    localparam int REPEAT_DLY   = 100;
    localparam int LAT_MAX      = 2 + 4 * SCAN_DIV + DEBOUNCE_CNT + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, key_held;

    logic [3:0][3:0] pressed = '0;   // pressed[col][row]

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [3:0] pulse_code[$];
    int         pulse_cyc[$];
    int         dbl_cnt = 0, silent_chg = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_code = 4'h0;

    keypad_scan_encoder #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .REPEAT_DLY(REPEAT_DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a driven (low) column pulls down the row of every closed switch on it.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_out[c]) row_in = row_in & ~pressed[c];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_code  <= key_code;
        end else begin
            if (key_valid) begin
                pulse_code.push_back(key_code);
                pulse_cyc.push_back(cyc);
            end
            if (key_valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
            if (!key_valid && key_code !== prev_code) silent_chg <= silent_chg + 1;
            prev_valid <= key_valid;
            prev_code  <= key_code;
        end
    end

    // Keypad face, one string per column, rows top to bottom; legend char -> code.
    function automatic logic [3:0] exp_code(input int c, input int r);
        string layout;
        int    v;
        case (c)
            0:       layout = "147*";
            1:       layout = "2580";
            2:       layout = "369#";
            default: layout = "ABCD";
        endcase
        v = int'(layout[r]);
        if (v >= 48 && v <= 57) return 4'(v - 48);   // '0'..'9'
        if (v >= 65 && v <= 68) return 4'(v - 55);   // 'A'..'D'
        if (v == 35) return 4'hE;                    // '#'
        return 4'hF;                                 // '*'
    endfunction

    function automatic int col_idx(input logic [3:0] co);
        case (co)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pulse_code.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_release(input int budget, output int took);
        int k = 0;
        while (key_held && k < budget) begin
            tick();
            k++;
        end
        took = k;
    endtask

    task automatic test_reset;
        int last, cur, run, bad;
        bit moved;
        pressed = '0;
        rst_n = 1'b0;
        tick(3);
        vectors += 4;
        if (col_out !== 4'b1110) begin miscompares++; $display("FAIL reset_col: got %b want 1110", col_out); end
        if (key_code !== 4'h0) begin miscompares++; $display("FAIL reset_code: got %h want 0", key_code); end
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", key_held); end
        rst_n = 1'b1;
        last = col_idx(col_out); run = 0; bad = 0; moved = 0;
        for (int k = 0; k < 10 * SCAN_DIV; k++) begin
            tick();
            cur = col_idx(col_out);
            if (cur < 0) bad++;
            else if (cur == last) run++;
            else begin
                if (cur != (last + 1) % 4) bad++;
                if (moved && run != SCAN_DIV) bad++;
                moved = 1; run = 1; last = cur;
            end
        end
        vectors++;
        if (bad != 0 || !moved) begin
            miscompares++;
            $display("FAIL scan_order: %0d bad steps, moved=%0d, want 0 bad and moving", bad, moved);
        end
    endtask

    task automatic test_single_press;
        int base, t0, took;
        base = pulse_code.size();
        pressed[1][1] = 1'b1;
        t0 = cyc;
        wait_pulses(base + 1, LAT_MAX + 5);
        vectors++;
        if (pulse_code.size() != base + 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d pulses want 1", pulse_code.size() - base);
        end else begin
            vectors += 2;
            if (pulse_code[base] !== exp_code(1, 1)) begin
                miscompares++; $display("FAIL single_code: got %h want %h", pulse_code[base], exp_code(1, 1));
            end
            if (pulse_cyc[base] - t0 > LAT_MAX) begin
                miscompares++; $display("FAIL single_latency: got %0d want <= %0d", pulse_cyc[base] - t0, LAT_MAX);
            end
        end
        tick(20);
        vectors++;
        if (key_held !== 1'b1 || key_code !== 4'h5) begin
            miscompares++; $display("FAIL single_held: got held=%b code=%h want 1/5", key_held, key_code);
        end
        pressed[1][1] = 1'b0;
        wait_release(DEBOUNCE_CNT + 10, took);
        vectors++;
        if (key_held !== 1'b0 || took < DEBOUNCE_CNT || took > DEBOUNCE_CNT + 5) begin
            miscompares++;
            $display("FAIL single_release: held=%b after %0d cycles want 0 within %0d..%0d",
                     key_held, took, DEBOUNCE_CNT, DEBOUNCE_CNT + 5);
        end
        tick(20);
        vectors++;
        if (pulse_code.size() != base + 1) begin
            miscompares++; $display("FAIL single_no_extra: got %0d pulses want 1", pulse_code.size() - base);
        end
    endtask

    task automatic test_sequence;
        int kc[3] = '{2, 0, 3};
        int base, took;
        base = pulse_code.size();
        for (int i = 0; i < 3; i++) begin
            pressed[kc[i]][3] = 1'b1;
            wait_pulses(base + i + 1, LAT_MAX + 5);
            tick(15);
            pressed[kc[i]][3] = 1'b0;
            wait_release(DEBOUNCE_CNT + 10, took);
            tick(5);
        end
        vectors++;
        if (pulse_code.size() != base + 3) begin
            miscompares++; $display("FAIL seq_count: got %0d pulses want 3", pulse_code.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (pulse_code[base + i] !== exp_code(kc[i], 3)) begin
                    miscompares++;
                    $display("FAIL seq_code%0d: got %h want %h", i, pulse_code[base + i], exp_code(kc[i], 3));
                end
            end
        end
    endtask

    task automatic test_glitch;
        int base, took;
        base = pulse_code.size();
        for (int i = 0; i < 4; i++) begin
            pressed[1][2] = 1'b1;
            tick($urandom_range(1, DEBOUNCE_CNT - 2));
            pressed[1][2] = 1'b0;
            tick($urandom_range(1, 12));
        end
        vectors++;
        if (pulse_code.size() != base) begin
            miscompares++; $display("FAIL glitch_press: got %0d pulses want 0", pulse_code.size() - base);
        end
        pressed[1][2] = 1'b1;
        wait_pulses(base + 1, LAT_MAX + 5);
        vectors++;
        if (pulse_code.size() != base + 1 || key_code !== 4'h8) begin
            miscompares++;
            $display("FAIL glitch_accept: got %0d pulses code %h want 1 pulse code 8", pulse_code.size() - base, key_code);
        end
        tick(5);
        for (int i = 0; i < 3; i++) begin
            pressed[1][2] = 1'b0;
            tick($urandom_range(1, DEBOUNCE_CNT - 2));
            pressed[1][2] = 1'b1;
            tick($urandom_range(1, DEBOUNCE_CNT - 2));
        end
        tick(3);
        vectors++;
        if (key_held !== 1'b1 || pulse_code.size() != base + 1) begin
            miscompares++;
            $display("FAIL glitch_release_bounce: held=%b pulses=%0d want 1/1", key_held, pulse_code.size() - base);
        end
        pressed[1][2] = 1'b0;
        wait_release(DEBOUNCE_CNT + 10, took);
        tick(20);
        vectors++;
        if (key_held !== 1'b0 || pulse_code.size() != base + 1) begin
            miscompares++;
            $display("FAIL glitch_final: held=%b pulses=%0d want 0/1", key_held, pulse_code.size() - base);
        end
    endtask

    task automatic test_multi_row;
        int base, bad;
        logic [3:0] seen;
        base = pulse_code.size();
        pressed[3][0] = 1'b1;
        pressed[3][2] = 1'b1;
        seen = '0; bad = 0;
        for (int k = 0; k < 25 * SCAN_DIV; k++) begin
            tick();
            if (col_idx(col_out) < 0) bad++;
            else seen[col_idx(col_out)] = 1'b1;
        end
        vectors += 2;
        if (pulse_code.size() != base) begin
            miscompares++; $display("FAIL multi_row_pulse: got %0d pulses want 0", pulse_code.size() - base);
        end
        if (seen !== 4'hF || bad != 0) begin
            miscompares++; $display("FAIL multi_row_scan: cols seen %b bad %0d want 1111/0", seen, bad);
        end
        pressed = '0;
        tick(5);
    endtask

    task automatic test_other_column;
        int base, took;
        base = pulse_code.size();
        pressed[1][1] = 1'b1;
        wait_pulses(base + 1, LAT_MAX + 5);
        pressed[0][0] = 1'b1;
        tick(40);
        vectors++;
        if (pulse_code.size() != base + 1 || key_code !== 4'h5 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL other_col: pulses=%0d code=%h held=%b want 1/5/1", pulse_code.size() - base, key_code, key_held);
        end
        pressed[0][0] = 1'b0;
        tick(5);
        pressed[1][1] = 1'b0;
        wait_release(DEBOUNCE_CNT + 10, took);
        tick(10);
        vectors++;
        if (key_held !== 1'b0 || pulse_code.size() != base + 1) begin
            miscompares++;
            $display("FAIL other_col_release: held=%b pulses=%0d want 0/1", key_held, pulse_code.size() - base);
        end
    endtask

    task automatic test_reset_in_held;
        int base, base2, took;
        base = pulse_code.size();
        pressed[0][2] = 1'b1;
        wait_pulses(base + 1, LAT_MAX + 5);
        tick(10);
        vectors++;
        if (pulse_code.size() != base + 1 || key_held !== 1'b1) begin
            miscompares++; $display("FAIL rst_held_setup: pulses=%0d held=%b want 1/1", pulse_code.size() - base, key_held);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: col=%b code=%h valid=%b held=%b want 1110/0/0/0", col_out, key_code, key_valid, key_held);
        end
        tick(4);
        rst_n = 1'b1;
        base2 = pulse_code.size();
        vectors++;
        if (base2 != base + 1) begin
            miscompares++; $display("FAIL rst_no_pulse: got %0d pulses want 1", base2 - base);
        end
        wait_pulses(base2 + 1, LAT_MAX + 5);
        tick(30);
        vectors++;
        if (pulse_code.size() != base2 + 1 || key_code !== exp_code(0, 2)) begin
            miscompares++;
            $display("FAIL rst_reacquire: pulses=%0d code=%h want 1/%h", pulse_code.size() - base2, key_code, exp_code(0, 2));
        end
        pressed[0][2] = 1'b0;
        wait_release(DEBOUNCE_CNT + 10, took);
        tick(5);
    endtask

    task automatic test_random;
        int base, t0, took, c, r;
        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            base = pulse_code.size();
            pressed[c][r] = 1'b1;
            t0 = cyc;
            wait_pulses(base + 1, LAT_MAX + 5);
            vectors++;
            if (pulse_code.size() != base + 1) begin
                miscompares++; $display("FAIL rand%0d_count: got %0d pulses want 1", it, pulse_code.size() - base);
            end else begin
                vectors += 2;
                if (pulse_code[base] !== exp_code(c, r)) begin
                    miscompares++; $display("FAIL rand%0d_code: got %h want %h", it, pulse_code[base], exp_code(c, r));
                end
                if (pulse_cyc[base] - t0 > LAT_MAX) begin
                    miscompares++; $display("FAIL rand%0d_latency: got %0d want <= %0d", it, pulse_cyc[base] - t0, LAT_MAX);
                end
            end
            tick($urandom_range(5, 50));
            pressed[c][r] = 1'b0;
            wait_release(DEBOUNCE_CNT + 10, took);
            vectors++;
            if (key_held !== 1'b0 || pulse_code.size() != base + 1) begin
                miscompares++;
                $display("FAIL rand%0d_release: held=%b pulses=%0d want 0/1", it, key_held, pulse_code.size() - base);
            end
            tick($urandom_range(0, 10));
        end
    endtask

    task automatic test_repeat;
        int base, acc, took, n_exp;
`ifdef KEYPAD_REPEAT_EN
        n_exp = 1 + 350 / REPEAT_DLY;
`else
        n_exp = 1;
`endif
        base = pulse_code.size();
        pressed[3][1] = 1'b1;
        wait_pulses(base + 1, LAT_MAX + 5);
        acc = (pulse_cyc.size() > base) ? pulse_cyc[base] : cyc;
        while (cyc < acc + 350) tick();
        pressed[3][1] = 1'b0;
        wait_release(DEBOUNCE_CNT + 10, took);
        tick(20);
        vectors++;
        if (pulse_code.size() != base + n_exp) begin
            miscompares++; $display("FAIL repeat_count: got %0d pulses want %0d", pulse_code.size() - base, n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                vectors++;
                if (pulse_code[base + i] !== 4'hB) begin
                    miscompares++; $display("FAIL repeat_code%0d: got %h want b", i, pulse_code[base + i]);
                end
            end
            for (int i = 1; i < n_exp; i++) begin
                vectors++;
                if (pulse_cyc[base + i] - pulse_cyc[base + i - 1] != REPEAT_DLY) begin
                    miscompares++;
                    $display("FAIL repeat_gap%0d: got %0d want %0d", i, pulse_cyc[base + i] - pulse_cyc[base + i - 1], REPEAT_DLY);
                end
            end
        end
    endtask

    task automatic test_pulse_integrity;
        vectors += 2;
        if (dbl_cnt != 0) begin
            miscompares++; $display("FAIL valid_width: %0d multi-cycle pulses want 0", dbl_cnt);
        end
        if (silent_chg != 0) begin
            miscompares++; $display("FAIL code_update: %0d code changes without valid want 0", silent_chg);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_sequence();
        test_glitch();
        test_multi_row();
        test_other_column();
        test_reset_in_held();
        test_random();
        test_repeat();
        test_pulse_integrity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/keypad_scan_encoder.md
# keypad_scan_encoder

Scans the calculator's 4x4 matrix keypad and encodes each debounced key press into the 4-bit key code consumed by the calculator control decoders. Codes: digits 0–9 = 0x0–0x9, A = 0xA, B (+) = 0xB, C (−) = 0xC, D (=) = 0xD, # (getM) = 0xE, * (setM) = 0xF. Sits between the keypad pins and the control path, which combines the code with the current 2-bit calculator state.

## Interface
- SCAN_DIV, 16: clock cycles each column is driven; must be ≥ 4.
- DEBOUNCE_CNT, 1000: consecutive stable cycles required for both press and release; ≥ 2.
- REPEAT_DLY, 500000: cycles held before the first auto-repeat and between repeats (used only with KEYPAD_REPEAT_EN).

- clk  in  1  single system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  out  4  column drive, active-low one-hot.
- key_code  out  4  last accepted key code, held until the next accepted key.
- key_valid  out  1  one-cycle pulse when key_code is updated.
- key_held  out  1  high from the acceptance of a key until its release is debounced.

## Operation
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- Key map (column, row): col0: 1,4,7,*; col1: 2,5,8,0; col2: 3,6,9,#; col3: A,B,C,D (rows 0–3 top to bottom).
- FSM states:
  - SCAN: col_out drives column c. On the last cycle of the SCAN_DIV slot, sample rs. If exactly one row is low → latch (c, row), go to DEB_PRESS. Otherwise advance c (3 wraps to 0).
  - DEB_PRESS: column stays driven. A counter increments each cycle while rs equals the latched pattern. Any difference → return to SCAN at column c+1. Once the count reaches DEBOUNCE_CNT → go to HELD, load key_code, pulse key_valid, and set key_held.
  - HELD: column stays driven. When rs becomes 4'b1111 → go to DEB_RELEASE.
  - DEB_RELEASE: count consecutive cycles with rs = 4'b1111. Any low row → return to HELD. Once the count reaches DEBOUNCE_CNT → clear key_held, go to SCAN at column 0.
- More than one low row in a sampled column is ignored; no code is produced.
- A second key pressed in another column while in HELD is ignored.
- Counters are sized with $clog2 of their parameter and saturate; they never wrap.

## Timing
- Reset values: col_out = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, FSM = SCAN at column 0, all counters = 0.
- Reset is asynchronous and can occur in any state; it returns the block to the reset values immediately, and no key_valid pulse follows.
- Latency from a clean, stable press to key_valid is at most 2 (sync) + 4·SCAN_DIV + DEBOUNCE_CNT + 1 cycles.
- key_valid is high for exactly 1 cycle. key_code changes in the same cycle that key_valid goes high.
- col_out changes only at slot boundaries in SCAN. Rows are sampled at least SCAN_DIV−1 cycles after a column change, which gives settle time and covers synchronizer delay.

## Configuration
- KEYPAD_REPEAT_EN defined: in HELD, a repeat counter runs. After REPEAT_DLY cycles, key_valid pulses again with the same key_code, the counter resets, and this repeats while the key stays held. The counter clears when leaving HELD.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per press; there is no repeat counter logic.

## Test plan
- Hold col1/row1 ('5') low, bounce-free → one key_valid pulse, key_code = 0x5, key_held = 1; release → key_held = 0 after DEBOUNCE_CNT stable cycles.
- Press '#' (col2, row3), then '*' (col0, row3), then 'D' (col3, row3) in sequence → key_code 0xE, then 0xF, then 0xD, with exactly three pulses.
- '8' press with glitches shorter than DEBOUNCE_CNT, followed by a stable press → no pulse during the glitches, one pulse with 0x8 after stabilizing; release bounce produces no second pulse.
- Rows 0 and 2 both low while col3 is driven → no key_valid; scanning continues through columns 0→3.
- Assert rst_n low while in HELD → outputs return to reset values asynchronously; after release of reset, the held key is reacquired with a single pulse.
- KEYPAD_REPEAT_EN with REPEAT_DLY = 100, holding 'B' for 350 cycles after acceptance → 1 initial pulse plus 3 repeat pulses, all 0xB; with the macro undefined → 1 pulse.
